sram_sync: RTL and testbench
============================

// Module: sram_sync
// PURPOSE
// - Clocked, parametrised single-port SRAM; successor to the 256x8 combinational bit-array SRAM.
// - Adds valid/ready request handshake, registered read data, hardware zero-fill after reset or on demand.
// - Generalises the array to DATA_W x 2**ADDR_W words.
// - Sits between a bus master or CPU datapath and local storage.
// PARAMETERS
// - DATA_W   8   data word width, bits (>=1)
// - ADDR_W   8   address width; DEPTH = 2**ADDR_W words
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        asynchronous active-low reset
// - clr        in   1        synchronous request to re-zero the whole array
// - cs         in   1        chip select; request ignored when 0
// - req_valid  in   1        request present
// - req_ready  out  1        block can accept a request this cycle
// - wr         in   1        1 = write, 0 = read (sampled with request)
// - addr       in   ADDR_W   word address
// - din        in   DATA_W   write data
// - rsp_valid  out  1        dout holds fresh read data (1-cycle pulse)
// - dout       out  DATA_W   read data, registered
// - init_done  out  1        1 once zero-fill finished and array usable
// - par_err    out  1        parity error flag (only with SRAM_PARITY_EN)
// BEHAVIOUR
// - Reset (rst_n=0, async): FSM=INIT, fill pointer=0, req_ready=0, rsp_valid=0, dout=0, init_done=0, par_err=0.
// - FSM states: INIT, IDLE.
// - INIT:
//   - Writes 0 to mem[ptr] each cycle; ptr increments.
//   - After writing ptr=DEPTH-1 -> IDLE; zero-fill takes exactly DEPTH cycles.
//   - init_done rises on the first IDLE cycle.
//   - req_ready=0 in INIT.
// - IDLE:
//   - req_ready=1. Accept = req_valid & req_ready & cs.
//   - Unaccepted cycles have no side effects.
// - Write accept: mem[addr] <= din at that edge; no response; rsp_valid stays 0.
// - Read accept:
//   - dout <= mem[addr] at that edge; rsp_valid=1 for the following cycle only (latency 1).
//   - dout holds its value until the next read; writes never change dout.
// - Back-to-back: one request per cycle sustained.
//   - Read of an address written in the previous cycle returns the new data.
// - clr=1 in IDLE:
//   - Next state INIT; ptr=0; init_done=0.
//   - clr has priority over a same-cycle request, which is not accepted (req_ready already 0 that cycle).
//   - clr during INIT restarts fill from ptr=0.
// - rsp_valid from a read accepted the cycle before clr still fires.
// - rst_n asserted mid-fill or mid-read: immediate return to reset values; fill restarts from 0 after release.
// - Address wrap: addr is exactly ADDR_W bits; no out-of-range case.
// CONFIGURATION
// - Macro SRAM_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, computed from din on write and forced to 0 on zero-fill.
//   - On a read, par_err <= parity mismatch, updated with rsp_valid and held until the next read.
//   - par_err resets to 0.
// - Macro SRAM_PARITY_EN undefined:
//   - No parity storage or parity logic.
//   - par_err port remains and is tied to 0.
// TESTING
// - Reset release, DATA_W=8 ADDR_W=4:
//   - req_ready=0 for 16 cycles, then req_ready=1 and init_done=1.
//   - Reads of all 16 addresses return 0x00.
// - Write 0xA5 to 0x3, then read 0x3 on the next cycle -> rsp_valid one cycle after the read accept, dout=0xA5.
// - Read with cs=0, req_valid=1 -> no rsp_valid; dout unchanged.
// - Read with cs=1, req_valid=0 -> no rsp_valid; dout unchanged.
// - Fill all addresses with addr^0x5A, pulse clr, wait 16 cycles -> all reads return 0x00.
// - Same-cycle clr and write are not accepted.
// - Assert rst_n=0 at fill cycle 7 -> outputs at reset values immediately; full 16-cycle fill repeats after release.
// - With SRAM_PARITY_EN, force a stored bit flip at 0x2 via hierarchical write, then read 0x2 -> par_err=1.
//   - Subsequent read of 0x4 -> par_err=0.

Source files
------------

// File: rtl/sram_sync.sv
// sram_sync: clocked single-port SRAM, valid/ready requests, zero-fill.
// Optional per-word even parity storage when SRAM_PARITY_EN is defined.
module sram_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cs,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] dout,
  output logic              init_done,
  output logic              par_err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic              acc;
  logic              rd_acc;
  logic              fill_last;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [MEM_W-1:0]  wd;

  assign fill_last = (ptr == ADDR_W'(DEPTH - 1));
  assign req_ready = (state == IDLE) & ~clr;
  assign acc       = req_valid & req_ready & cs;
  assign rd_acc    = acc & ~wr;
  assign init_done = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (1'b1)
      clr: begin
        state_nxt = INIT;
        ptr_nxt   = '0;
      end
      (~clr & (state == INIT)): begin
        ptr_nxt = ptr + 1'b1;
        if (fill_last) state_nxt = IDLE;
      end
      (~clr & (state == IDLE)): begin
        ptr_nxt = ptr;
      end
    endcase
  end

  // Fill and request writes share the single write port; INIT excludes acc.
  always_comb begin
    we = 1'b0;
    wa = addr;
    wd = '0;
    unique case (1'b1)
      (state == INIT): begin
        we = 1'b1;
        wa = ptr;
      end
      (acc & wr): begin
        we = 1'b1;
`ifdef SRAM_PARITY_EN
        wd = {^din, din};
`else
        wd = din;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      dout      <= '0;
    end else begin
      rsp_valid <= rd_acc;
      if (rd_acc) dout <= mem[addr][DATA_W-1:0];
    end
  end

`ifdef SRAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (rd_acc) begin
      par_err <= ^mem[addr];
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sync.sv
// tb_sram_sync: random + directed checks of sram_sync (8x16)
// against a word-array reference model with a fill countdown.
module tb_sram_sync;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       cs;
  logic       req_valid;
  logic       req_ready;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] din;
  logic       rsp_valid;
  logic [7:0] dout;
  logic       init_done;
  logic       par_err;

  sram_sync #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cs(cs),
    .req_valid(req_valid), .req_ready(req_ready),
    .wr(wr), .addr(addr), .din(din),
    .rsp_valid(rsp_valid), .dout(dout),
    .init_done(init_done), .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk;
  int         n_fail;
  logic [7:0] mm [16];
  bit         bad [16];
  int         fill_left;
  logic       exp_rv;
  logic [7:0] exp_dout;
  logic       exp_pe;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic k);
    chk("req_ready", 32'(req_ready), 32'((fill_left == 0) && !k));
    chk("init_done", 32'(init_done), 32'(fill_left == 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("par_err", 32'(par_err), 32'(exp_pe));
  endtask

  task automatic model_reset();
    fill_left = 16;
    exp_rv    = 1'b0;
    exp_dout  = 8'h00;
    exp_pe    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mm[i]  = 8'h00;
      bad[i] = 1'b0;
    end
  endtask

  task automatic step(input logic c, input logic v, input logic w,
                      input logic [3:0] a, input logic [7:0] d,
                      input logic k);
    logic acc;
    cs = c; req_valid = v; wr = w;
    addr = a; din = d; clr = k;
    acc = (fill_left == 0) && !k && c && v;
    @(posedge clk); #1;
    exp_rv = acc && !w;
    if (acc && w) begin
      mm[a]  = d;
      bad[a] = 1'b0;
    end
    if (acc && !w) begin
      exp_dout = mm[a];
      exp_pe   = bad[a];
    end
    if (k) begin
      fill_left = 16;
      for (int i = 0; i < 16; i++) begin
        mm[i]  = 8'h00;
        bad[i] = 1'b0;
      end
    end else if (fill_left > 0) begin
      fill_left--;
    end
    chk_all(k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 8'h00, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1, 1, 0, a, 8'h00, 0);
  endtask

  task automatic wrt(input logic [3:0] a, input logic [7:0] d);
    step(1, 1, 1, a, d, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp", 32'(rsp_valid), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_done", 32'(init_done), 32'(0));
    chk("rst_perr", 32'(par_err), 32'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; clr = 1'b0; cs = 1'b0;
    req_valid = 1'b0; wr = 1'b0;
    addr = 4'h0; din = 8'h00;
    model_reset();
    #2;
    do_reset();

    idle(15);
    chk("fill_wait_ready", 32'(req_ready), 32'(0));
    idle(1);
    chk("fill_end_ready", 32'(req_ready), 32'(1));
    chk("fill_end_done", 32'(init_done), 32'(1));
    for (int i = 0; i < 16; i++) rd(4'(i));

    wrt(4'h3, 8'hA5);
    rd(4'h3);
    chk("rd_a5_valid", 32'(rsp_valid), 32'(1));
    chk("rd_a5_dout", 32'(dout), 32'(8'hA5));
    idle(1);
    chk("rsp_pulse", 32'(rsp_valid), 32'(0));

    step(0, 1, 0, 4'h0, 8'h00, 0);
    chk("cs0_dout", 32'(dout), 32'(8'hA5));
    step(1, 0, 0, 4'h0, 8'h00, 0);
    chk("rv0_dout", 32'(dout), 32'(8'hA5));
    step(0, 1, 1, 4'h3, 8'h11, 0);
    rd(4'h3);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)),
           4'($urandom), 8'($urandom),
           $urandom_range(0, 63) == 0);
    end
    idle(16);

    for (int i = 0; i < 16; i++) wrt(4'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 16; i += 5) rd(4'(i));
    step(0, 0, 0, 4'h0, 8'h00, 1);
    idle(16);
    chk("clr_done", 32'(init_done), 32'(1));
    for (int i = 0; i < 16; i++) rd(4'(i));

    wrt(4'h1, 8'h42);
    rd(4'h1);
    step(1, 1, 1, 4'h1, 8'hFF, 1);
    chk("rd_before_clr", 32'(rsp_valid), 32'(0));
    idle(16);
    rd(4'h1);
    chk("clr_wr_blocked", 32'(dout), 32'(0));

    step(0, 0, 0, 4'h0, 8'h00, 1);
    idle(7);
    do_reset();
    idle(15);
    chk("refill_wait", 32'(req_ready), 32'(0));
    idle(1);
    wrt(4'h9, 8'hC3);
    rd(4'h9);
    do_reset();
    idle(16);
    rd(4'h9);

`ifdef SRAM_PARITY_EN
    wrt(4'h2, 8'h3C);
    wrt(4'h4, 8'h77);
    dut.mem[2] = dut.mem[2] ^ 9'h100;
    bad[2] = 1'b1;
    rd(4'h2);
    chk("par_flip", 32'(par_err), 32'(1));
    rd(4'h4);
    chk("par_clean", 32'(par_err), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
